button_event_ctrl: RTL and testbench

- Turns up to N debounced, synchronized button levels into discrete events: press, release, long-press and auto-repeat.
- Round-robin arbitration merges the per-button events into a single valid/ready event stream for the menu/UI logic.
- Sits downstream of the per-button debounce/sync stages and upstream of the bench's mode/display controller.
- Contains its own tick prescaler, so all hold timing is in ticks, not raw clocks.

---
 rtl/button_event_ctrl.sv | 175 +++++++++++++++++
 tb/tb_button_event_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Button event generator: per-button press/release/long/repeat detection with one-deep
// pending slots, merged into a single valid/ready stream by a round-robin arbiter.
module button_event_ctrl #(
  parameter int N            = 4,
  parameter int TICK_DIV     = 12000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  localparam int IDW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   btn,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [IDW-1:0] ev_id,
  output logic [1:0]     ev_kind,
  output logic           ovf
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  localparam logic [1:0] KIND_PRESS   = 2'd0;
  localparam logic [1:0] KIND_RELEASE = 2'd1;
  localparam logic [1:0] KIND_LONG    = 2'd2;
  localparam logic [1:0] KIND_REPEAT  = 2'd3;

  typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;

  logic [PW-1:0]  presc;
  logic           tick;
  logic [N-1:0]   btn_q;
  logic [N-1:0]   pend_v;
  logic [1:0]     pend_k [N];
  logic [N-1:0]   drop;
  logic [N-1:0]   gnt;
  logic           load;
  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] rr;

  assign tick = (presc == PW'(TICK_DIV - 1));
  assign load = ~ev_valid | ev_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      btn_q <= '0;
      ovf   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      btn_q <= btn;
      if (|drop) ovf <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_btn
      state_t        state;
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_inc;
      logic          emit;
      logic [1:0]    ekind;
      logic          slot_v;
      logic [1:0]    slot_k;

      assign cnt_inc     = cnt + 1'b1;
      assign pend_v[gi]  = slot_v;
      assign pend_k[gi]  = slot_k;
      assign drop[gi]    = emit & slot_v & ~gnt[gi];

      // Release wins over a coincident tick, so a long/repeat never follows the drop of btn.
      always_comb begin
        emit  = 1'b0;
        ekind = KIND_PRESS;
        case (state)
          IDLE: emit = btn[gi] & ~btn_q[gi];
          HELD: begin
            if (!btn[gi]) begin
              emit  = 1'b1;
              ekind = KIND_RELEASE;
            end else if (tick && cnt_inc == CW'(LONG_TICKS)) begin
              emit  = 1'b1;
              ekind = KIND_LONG;
            end
          end
          RPT: begin
            if (!btn[gi]) begin
              emit  = 1'b1;
              ekind = KIND_RELEASE;
            end else if (tick && cnt_inc == CW'(REPEAT_TICKS)) begin
              emit  = 1'b1;
              ekind = KIND_REPEAT;
            end
          end
          default: emit = 1'b0;
        endcase
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state  <= IDLE;
          cnt    <= '0;
          slot_v <= 1'b0;
          slot_k <= KIND_PRESS;
        end else begin
          case (state)
            IDLE: if (btn[gi] && !btn_q[gi]) begin
              state <= HELD;
              cnt   <= '0;
            end
            HELD: begin
              if (!btn[gi]) state <= IDLE;
              else if (tick) begin
                if (cnt_inc == CW'(LONG_TICKS)) begin
                  state <= RPT;
                  cnt   <= '0;
                end else cnt <= cnt_inc;
              end
            end
            RPT: begin
              if (!btn[gi]) state <= IDLE;
              else if (tick) cnt <= (cnt_inc == CW'(REPEAT_TICKS)) ? '0 : cnt_inc;
            end
            default: state <= IDLE;
          endcase
          // A slot being granted this cycle frees up in time to take the new event.
          if (emit && (!slot_v || gnt[gi])) begin
            slot_v <= 1'b1;
            slot_k <= ekind;
          end else if (gnt[gi]) begin
            slot_v <= 1'b0;
          end
        end
      end
    end
  endgenerate

  // Scan from farthest to nearest so the first pending slot at/after rr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int j = N - 1; j >= 0; j--) begin
      idx = IDW'((int'(rr) + j) % N);
      if (pend_v[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
    gnt = '0;
    if (load && gnt_any) gnt[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_kind  <= KIND_PRESS;
      rr       <= '0;
    end else if (load) begin
      if (gnt_any) begin
        ev_valid <= 1'b1;
        ev_id    <= gnt_id;
        ev_kind  <= pend_k[gnt_id];
        rr       <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
      end else begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: expected events are queued as stimulus is driven
// and compared against each accepted output event.
module tb_button_event_ctrl;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = '0;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [1:0] ev_id;
  logic [1:0] ev_kind;
  logic       ovf;

  int total = 0;
  int npass = 0;
  int nfail = 0;
  int ecnt = 0;
  int base = 0;
  logic [3:0] sb[$];
  int ord_a[3];
  int ord_b[3];

  button_event_ctrl #(.N(N), .TICK_DIV(4), .LONG_TICKS(3), .REPEAT_TICKS(2)) dut (
    .clk(clk), .reset(rst_n), .btn(btn), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_id(ev_id), .ev_kind(ev_kind), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int id, input int kind);
    sb.push_back(4'(id * 4 + kind));
  endtask

  task automatic drain(input int n, input string tag);
    repeat (n) step();
    chk(tag, sb.size(), 0);
  endtask

  // Ticks land on edges whose count since reset release is a multiple of 4.
  task automatic align();
    while (((ecnt - base) % 4) != 0) step();
  endtask

  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      logic [3:0] e;
      total++;
      assert (sb.size() > 0) npass++;
      else begin
        nfail++;
        $error("FAIL sb_extra observed id=%0d kind=%0d expected none", ev_id, ev_kind);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_id", int'(ev_id), int'(e[3:2]));
        chk("sb_kind", int'(ev_kind), int'(e[1:0]));
        $display("event id=%0d kind=%0d", ev_id, ev_kind);
      end
    end
  end

  initial begin
    ord_a = '{1, 2, 3};
    ord_b = '{3, 0, 1};

    step();
    step();
    chk("rst_valid", ev_valid, 0);
    chk("rst_id", int'(ev_id), 0);
    chk("rst_kind", int'(ev_kind), 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    base = ecnt;

    // Round robin from pointer 0
    ev_ready = 1'b0;
    btn = 4'hF;
    for (int i = 0; i < 4; i++) push(i, 0);
    step();
    chk("rr_a_pend", ev_valid, 0);
    step();
    chk("rr_a_valid", ev_valid, 1);
    chk("rr_a_first", int'(ev_id), 0);
    step();
    chk("rr_a_stall_id", int'(ev_id), 0);
    chk("rr_a_stall_kind", int'(ev_kind), 0);
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_a_b2b_valid", ev_valid, 1);
      chk("rr_a_b2b_id", int'(ev_id), ord_a[i]);
    end
    step();
    btn = 4'h0;
    for (int i = 0; i < 4; i++) push(i, 1);
    drain(8, "rr_a_drain");

    // Move the pointer to 2 via a single press/release on button 1
    btn = 4'b0010;
    push(1, 0);
    step();
    step();
    btn = 4'h0;
    push(1, 1);
    drain(5, "rr_ptr_drain");

    // Round robin from pointer 2
    ev_ready = 1'b0;
    btn = 4'hF;
    push(2, 0); push(3, 0); push(0, 0); push(1, 0);
    step();
    step();
    chk("rr_b_first", int'(ev_id), 2);
    step();
    chk("rr_b_stall_id", int'(ev_id), 2);
    ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_b_b2b_valid", ev_valid, 1);
      chk("rr_b_b2b_id", int'(ev_id), ord_b[i]);
    end
    step();
    btn = 4'h0;
    push(2, 1); push(3, 1); push(0, 1); push(1, 1);
    drain(8, "rr_b_drain");

    // Press/release latency on button 2
    btn = 4'b0100;
    push(2, 0);
    step();
    chk("t1_lat_k", ev_valid, 0);
    step();
    chk("t1_lat_valid", ev_valid, 1);
    chk("t1_lat_id", int'(ev_id), 2);
    chk("t1_lat_kind", int'(ev_kind), 0);
    repeat (3) step();
    btn = 4'h0;
    push(2, 1);
    drain(5, "t1_drain");
    chk("t1_ovf", ovf, 0);

    // Long then repeats on button 0, press aligned just after a tick
    align();
    btn = 4'b0001;
    push(0, 0); push(0, 2); push(0, 3); push(0, 3);
    for (int j = 1; j <= 30; j++) begin
      step();
      if (j == 13) begin
        chk("t2_long_valid", ev_valid, 1);
        chk("t2_long_kind", int'(ev_kind), 2);
      end
      if (j == 21) chk("t2_rpt_kind", int'(ev_kind), 3);
    end
    btn = 4'h0;
    push(0, 1);
    drain(5, "t2_drain");

    // Release coincides with the grant of its own pending press
    btn = 4'b0010;
    push(1, 0); push(1, 1);
    step();
    btn = 4'h0;
    step();
    chk("t5_press_id", int'(ev_id), 1);
    chk("t5_press_kind", int'(ev_kind), 0);
    step();
    chk("t5_rel_valid", ev_valid, 1);
    chk("t5_rel_kind", int'(ev_kind), 1);
    drain(4, "t5_drain");
    chk("t5_ovf", ovf, 0);

    // Backpressure: press stalled, release in slot, second press dropped
    ev_ready = 1'b0;
    btn = 4'b0010;
    push(1, 0);
    step();
    step();
    chk("t4_out_valid", ev_valid, 1);
    chk("t4_out_id", int'(ev_id), 1);
    btn = 4'h0;
    push(1, 1);
    step();
    chk("t4_stall_kind", int'(ev_kind), 0);
    chk("t4_ovf_pre", ovf, 0);
    btn = 4'b0010;
    step();
    chk("t4_ovf_set", ovf, 1);
    chk("t4_stall_id", int'(ev_id), 1);
    step();
    chk("t4_stall_valid", ev_valid, 1);
    chk("t4_stall_kind2", int'(ev_kind), 0);
    ev_ready = 1'b1;
    drain(4, "t4_drain");
    chk("t4_ovf_sticky", ovf, 1);
    btn = 4'h0;
    push(1, 1);
    drain(5, "t4_final_drain");
    chk("t4_ovf_end", ovf, 1);

    // Asynchronous reset with button 3 held in the repeat phase
    ev_ready = 1'b0;
    align();
    btn = 4'b1000;
    repeat (13) step();
    chk("t6_pre_valid", ev_valid, 1);
    chk("t6_pre_id", int'(ev_id), 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", ev_valid, 0);
    chk("t6_rst_id", int'(ev_id), 0);
    chk("t6_rst_kind", int'(ev_kind), 0);
    chk("t6_rst_ovf", ovf, 0);
    #1;
    rst_n = 1'b1;
    base = ecnt;
    ev_ready = 1'b1;
    push(3, 0);
    step();
    chk("t6_lat_k", ev_valid, 0);
    step();
    chk("t6_press_valid", ev_valid, 1);
    chk("t6_press_id", int'(ev_id), 3);
    chk("t6_press_kind", int'(ev_kind), 0);
    btn = 4'h0;
    push(3, 1);
    drain(5, "t6_drain");
    chk("t6_ovf", ovf, 0);

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
